// File: rtl/f_pc_gen.sv
// Fetch PC generator: priority redirect mux, stall hold, optional return-address stack.
// Define PC_RAS_EN to build the return-address stack; without it ras_push/ras_pop are ignored.
module f_pc_gen #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(32'h0000_4180),
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_valid,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc_valid,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] epc,
  input  logic             ras_push,
  input  logic [WIDTH-1:0] ras_push_addr,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr_addr,
  output logic             pc_misalign,
  output logic             redirect,
  output logic             ras_empty
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic             redirect_q;
  logic             redirect_d;
  logic             ras_hit;
  logic [WIDTH-1:0] ras_top;
  logic             ras_op;

  assign ras_op = en & ~exc_valid & ~eret_valid;

`ifdef PC_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] stack_q [RAS_DEPTH];
  logic [PW-1:0]    top_q;
  logic [PW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign ras_empty = (cnt_q == '0);
  assign ras_top   = stack_q[top_q];
  assign ras_hit   = ras_pop & ~ras_empty;
  assign do_push   = ras_op & ras_push;
  assign do_pop    = ras_op & ras_hit;

  // Circular buffer: a push on a full stack naturally overwrites the oldest slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (exc_valid) begin
      cnt_q <= '0;
    end else if (do_push && do_pop) begin
      top_q <= top_q;
    end else if (do_push) begin
      top_q <= top_q + 1'b1;
      if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
    end else if (do_pop) begin
      top_q <= top_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && do_pop) stack_q[top_q] <= ras_push_addr;
    else if (do_push) stack_q[top_q + 1'b1] <= ras_push_addr;
  end
`else
  logic unused_ras;

  assign unused_ras = ^{ras_push, ras_pop, ras_push_addr};
  assign ras_empty  = 1'b1;
  assign ras_hit    = 1'b0;
  assign ras_top    = '0;
`endif

  assign pc_inc = pc_q + WIDTH'(4);

  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    if (exc_valid) begin
      pc_d       = EXC_VEC;
      redirect_d = 1'b1;
    end else if (eret_valid) begin
      pc_d       = epc;
      redirect_d = 1'b1;
    end else if (!en) begin
      pc_d       = pc_q;
    end else if (br_valid) begin
      pc_d       = br_target;
      redirect_d = 1'b1;
    end else if (jmp_valid) begin
      pc_d       = jmp_target;
      redirect_d = 1'b1;
    end else if (ras_hit) begin
      pc_d       = ras_top;
      redirect_d = 1'b1;
    end else begin
      pc_d       = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_VEC;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc          = pc_q;
  assign instr_addr  = pc_q;
  assign pc_misalign = |pc_q[1:0];
  assign redirect    = redirect_q;

endmodule

// File: doc/f_pc_gen.md
F_PC_GEN -- requirements
Module: f_pc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning PC/address width in bits (>= 8).
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_3000, meaning PC value loaded on reset.
REQ-003 SHALL have parameter EXC_VEC, default 32'h0000_4180, meaning exception handler entry address.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of 2, >= 2).
REQ-005 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-007 SHALL have port en  input  1  fetch enable; 0 = stall, PC holds.
REQ-008 SHALL have ports br_valid input 1 and br_target input WIDTH, meaning branch redirect.
REQ-009 SHALL have ports jmp_valid input 1 and jmp_target input WIDTH, meaning jump redirect.
REQ-010 SHALL have port exc_valid  input  1  exception request.
REQ-011 SHALL have ports eret_valid input 1 and epc input WIDTH, meaning exception return to epc.
REQ-012 SHALL have ports ras_push input 1 and ras_push_addr input WIDTH, meaning call return address push.
REQ-013 SHALL have port ras_pop  input  1  predicted return; redirect to stack top.
REQ-014 SHALL have ports pc output WIDTH and instr_addr output WIDTH, both equal to the PC register.
REQ-015 SHALL have port pc_misalign  output  1  combinational, 1 when pc[1:0] != 0.
REQ-016 SHALL have port redirect  output  1  registered, 1 for the cycle after a non-sequential load.
REQ-017 SHALL have port ras_empty  output  1  1 when the stack holds no entries.

Function
REQ-018 SHALL select next PC by fixed priority: exc_valid > eret_valid > br_valid > jmp_valid > ras_pop (stack non-empty) > pc+4.
REQ-019 SHALL load EXC_VEC on exc_valid, and epc on eret_valid, regardless of en.
REQ-020 SHALL apply br, jmp, ras_pop and sequential updates only when en=1; when en=0 and no exc/eret, pc and stack SHALL hold.
REQ-021 SHALL compute pc+4 modulo 2^WIDTH (all-ones-minus-3 wraps to 0), with no flag.
REQ-022 SHALL set redirect=1 in the cycle following any load from exc, eret, br, jmp or ras; 0 otherwise, including during stall.
REQ-023 SHALL, with ras_pop on an empty stack, take the next lower-priority source; pointer SHALL NOT underflow.
REQ-024 SHALL, with ras_push on a full stack, overwrite the oldest entry; count saturates at RAS_DEPTH.
REQ-025 SHALL, with push and pop in the same enabled cycle, redirect to the current top, then replace the top with ras_push_addr (count unchanged); on an empty stack, the push alone SHALL take effect.
REQ-026 SHALL process push/pop only when en=1 and neither exc_valid nor eret_valid is set.
REQ-027 SHALL clear the stack (count=0) on exc_valid.
REQ-028 SHALL perform a stack pop even when a higher-priority br/jmp wins the PC selection (speculative call/return bookkeeping is kept).

Reset
REQ-029 SHALL, while reset=0, asynchronously force pc=RESET_VEC, redirect=0, stack count=0, ras_empty=1.
REQ-030 SHALL, on reset asserted mid-operation, discard any pending redirect; the first edge after release SHALL load RESET_VEC+4 if en=1.

Configuration
REQ-031 SHALL compile the return-address stack only when macro PC_RAS_EN is defined.
REQ-032 SHALL, without PC_RAS_EN, keep all ports, ignore ras_push/ras_pop, tie ras_empty=1, and use no stack storage.

Verification
REQ-033 SHALL test reset: reset=0 for 2 cycles mid-run, then release with en=1 -> pc=0x3000, then 0x3004, redirect=0.
REQ-034 SHALL test stall plus exception: en=0 at pc=0x3010, exc_valid=1 for 1 cycle -> next pc=0x4180, redirect=1 one cycle, ras_empty=1.
REQ-035 SHALL test priority: br_valid=1 (0x3100) and jmp_valid=1 (0x3200) together -> pc=0x3100; eret_valid=1 (epc=0x3050) with br -> pc=0x3050.
REQ-036 SHALL test the RAS (PC_RAS_EN): push 0x3008, 0x3018, pop -> pc=0x3018; pop -> 0x3008; pop on empty -> pc+4, ras_empty=1.
REQ-037 SHALL test overflow and wrap: 5 pushes at depth 4 (A..E), 4 pops -> E, D, C, B; separately pc=0xFFFF_FFFC with en=1 -> pc=0x0000_0000, pc_misalign=0.
REQ-038 SHALL test no-macro build: ras_pop=1 after a push -> pc=pc+4, ras_empty stays 1.
